// File: rtl/button_voice.sv
// button_voice: key events, 8-note square oscillator and A/S/R envelope
// driven by the registered button-index code (0..7 key, anything else none).
module button_voice #(
  parameter int unsigned SAMPLE_DIV   = 1000,
  parameter int unsigned PHASE_W      = 16,
  parameter int unsigned ATTACK_STEP  = 8,
  parameter int unsigned RELEASE_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          button,
  output logic                gate,
  output logic [2:0]          note,
  output logic                note_on,
  output logic                note_off,
  output logic [7:0]          sample,
  output logic                sample_valid
);

  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned INC_SH = PHASE_W - 16;
  localparam logic [3:0]  KEY_NONE = 4'd15;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           env_q, env_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0]     div_q;
  logic [3:0]           prev_key_q;
  logic [3:0]           key;
  logic                 tick;
  logic                 key_event;
  logic [8:0]           attack_sum;
  logic [2:0]           note_d;
  logic                 gate_d, note_on_d, note_off_d, sample_valid_d;
  logic [7:0]           sample_d;

  // Per-note phase increment, scaled up for wider accumulators
  function automatic logic [PHASE_W-1:0] inc_of(input logic [2:0] n);
    logic [15:0] base;
    case (n)
      3'd0:    base = 16'd274;
      3'd1:    base = 16'd308;
      3'd2:    base = 16'd345;
      3'd3:    base = 16'd366;
      3'd4:    base = 16'd411;
      3'd5:    base = 16'd461;
      3'd6:    base = 16'd518;
      default: base = 16'd549;
    endcase
    return PHASE_W'(base) << INC_SH;
  endfunction

  // Key decode, sample tick and key-change detection
  always_comb begin
    key       = (button <= 5'd7) ? {1'b0, button[2:0]} : KEY_NONE;
    tick      = (div_q == DIV_W'(SAMPLE_DIV - 1));
    key_event = (key != prev_key_q);
  end

  // Next-state, envelope, phase and output computation
  always_comb begin
    state_d        = state_q;
    env_d          = env_q;
    phase_d        = phase_q;
    note_d         = note;
    note_on_d      = 1'b0;
    note_off_d     = 1'b0;
    sample_d       = sample;
    sample_valid_d = 1'b0;
    attack_sum     = {1'b0, env_q} + 9'(ATTACK_STEP);

    // envelope and oscillator advance once per sample tick
    if (tick) begin
      unique case (state_q)
        IDLE:    env_d = 8'd0;
        ATTACK: begin
          if (attack_sum >= 9'd255) begin
            env_d   = 8'd255;
            state_d = SUSTAIN;
          end else begin
            env_d = attack_sum[7:0];
          end
        end
        SUSTAIN: env_d = env_q;
        RELEASE: begin
          if ({1'b0, env_q} <= 9'(RELEASE_STEP)) begin
            env_d   = 8'd0;
            state_d = IDLE;
          end else begin
            env_d = env_q - 8'(RELEASE_STEP);
          end
        end
      endcase
      if (state_q != IDLE) phase_d = phase_q + inc_of(note);
    end

    // key events override any envelope-driven transition
    if (key_event) begin
      unique case (state_q)
        IDLE: begin
          if (key != KEY_NONE) begin
            state_d   = ATTACK;
            note_d    = key[2:0];
            note_on_d = 1'b1;
            phase_d   = '0;
          end
        end
        ATTACK, SUSTAIN: begin
          if (key == KEY_NONE) begin
            state_d    = RELEASE;
            note_off_d = 1'b1;
          end else begin
            state_d   = ATTACK;
            note_d    = key[2:0];
            note_on_d = 1'b1;
          end
        end
        RELEASE: begin
          if (key != KEY_NONE) begin
            state_d   = ATTACK;
            note_d    = key[2:0];
            note_on_d = 1'b1;
          end
        end
      endcase
    end

    gate_d = (state_d == ATTACK) || (state_d == SUSTAIN);

    if (tick) begin
      sample_d       = phase_d[PHASE_W-1] ? env_d : 8'd0;
      sample_valid_d = 1'b1;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      env_q        <= 8'd0;
      phase_q      <= '0;
      div_q        <= '0;
      prev_key_q   <= KEY_NONE;
      gate         <= 1'b0;
      note         <= 3'd0;
      note_on      <= 1'b0;
      note_off     <= 1'b0;
      sample       <= 8'd0;
      sample_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      env_q        <= env_d;
      phase_q      <= phase_d;
      div_q        <= tick ? '0 : div_q + 1'b1;
      prev_key_q   <= key;
      gate         <= gate_d;
      note         <= note_d;
      note_on      <= note_on_d;
      note_off     <= note_off_d;
      sample       <= sample_d;
      sample_valid <= sample_valid_d;
    end
  end

endmodule

// File: tb/tb_button_voice.sv
// Randomised + directed bench for button_voice with a queue scoreboard.
module tb_button_voice;

  localparam int DIV = 4;
  localparam int AS  = 64;
  localparam int RS  = 32;
  localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] button;
  logic       gate, note_on, note_off, sample_valid;
  logic [2:0] note;
  logic [7:0] sample;

  button_voice #(
    .SAMPLE_DIV(DIV), .PHASE_W(16), .ATTACK_STEP(AS), .RELEASE_STEP(RS)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .gate(gate), .note(note),
    .note_on(note_on), .note_off(note_off), .sample(sample),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; bit on; bit off; bit sv; int note; bit gate; int sample;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   inc_tab[8] = '{274, 308, 345, 366, 411, 461, 518, 549};

  // reference model state
  int m_state, m_env, m_phase, m_note, m_prev, m_div, m_sample;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_state = M_IDLE; m_env = 0; m_phase = 0; m_note = 0;
    m_prev = 15; m_div = 0; m_sample = 0;
  endfunction

  // Predicts the DUT's response at the coming clock edge for input b
  function automatic void model_step(input int b);
    int key, st, env, ph, nt;
    bit on, off, tick;
    exp_t e;
    key  = (b <= 7) ? b : 15;
    tick = (m_div == DIV - 1);
    st = m_state; env = m_env; ph = m_phase; nt = m_note; on = 0; off = 0;
    if (tick) begin
      if (m_state == M_ATK) begin
        env = (env + AS > 255) ? 255 : env + AS;
        if (env == 255) st = M_SUS;
      end else if (m_state == M_REL) begin
        env = (env - RS < 0) ? 0 : env - RS;
        if (env == 0) st = M_IDLE;
      end else if (m_state == M_IDLE) begin
        env = 0;
      end
      if (m_state != M_IDLE) ph = (ph + inc_tab[m_note]) % 65536;
    end
    if (key != m_prev) begin
      if (m_state == M_IDLE && key != 15) begin
        st = M_ATK; nt = key; ph = 0; on = 1;
      end else if (m_state == M_ATK || m_state == M_SUS) begin
        if (key == 15) begin st = M_REL; off = 1; end
        else begin st = M_ATK; nt = key; on = 1; end
      end else if (m_state == M_REL && key != 15) begin
        st = M_ATK; nt = key; on = 1;
      end
    end
    if (tick) m_sample = (ph >= 32768) ? env : 0;
    m_state = st; m_env = env; m_phase = ph; m_note = nt;
    m_prev = key; m_div = (m_div + 1) % DIV;
    if (on || off || tick) begin
      e.cyc = cyc + 1; e.on = on; e.off = off; e.sv = tick; e.note = nt;
      e.gate = (st == M_ATK || st == M_SUS); e.sample = m_sample;
      q.push_back(e);
    end
  endfunction

  // Monitor: pops an expectation whenever the DUT pulses an output
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst && (note_on || note_off || sample_valid)) begin
        checks++;
        if (note_on && note_off) begin
          errors++;
          $display("FAIL on_off_exclusive cyc=%0d got on=1 off=1, required not both", cyc);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got on=%0b off=%0b sv=%0b, required no pulse",
                   cyc, note_on, note_off, sample_valid);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.on != note_on || e.off != note_off || e.sv != sample_valid ||
              e.note != int'(note) || e.gate != gate || e.sample != int'(sample)) begin
            errors++;
            $display("FAIL pulse cyc=%0d got on=%0b off=%0b sv=%0b note=%0d gate=%0b sample=%0d, required cyc=%0d on=%0b off=%0b sv=%0b note=%0d gate=%0b sample=%0d",
                     cyc, note_on, note_off, sample_valid, note, gate, sample,
                     e.cyc, e.on, e.off, e.sv, e.note, e.gate, e.sample);
          end
        end
      end else if (!rst && q.size() > 0 && q[0].cyc <= cyc) begin
        checks++; errors++;
        e = q.pop_front();
        $display("FAIL missing_pulse cyc=%0d got none, required on=%0b off=%0b sv=%0b sample=%0d",
                 cyc, e.on, e.off, e.sv, e.sample);
      end
    end
  end

  task automatic step(input int b, input int n);
    repeat (n) begin
      @(negedge clk);
      button = 5'(b);
      model_step(b);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({gate, note, note_on, note_off, sample, sample_valid} != 15'd0) begin
      errors++;
      $display("FAIL %s got gate=%0b note=%0d on=%0b off=%0b sample=%0d sv=%0b, required all 0",
               tag, gate, note, note_on, note_off, sample, sample_valid);
    end
  endtask

  task automatic assert_rst();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_at_reset got %0d pending, required 0", q.size());
    end
    q.delete();
    model_reset();
  endtask

  task automatic release_rst(input int b, input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    button = 5'(b);
    model_step(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bit found;
    rst = 1'b1;
    button = 5'd15;
    model_reset();
    #1;
    check_reset_outputs("power_on_reset");
    release_rst(15, 2);
    step(15, 20);

    // press, attack to sustain, release to idle
    step(2, 30);
    step(15, 40);

    // legato switch from sustain
    step(0, 24);
    step(5, 12);
    step(15, 40);

    // invalid codes
    step(9, 10);
    step(3, 10);
    step(12, 40);

    // release on the same edge attack saturates
    step(6, 1);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (m_state == M_ATK && m_env == 192 && m_div == DIV - 1) begin
        found = 1;
        break;
      end
      step(6, 1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL saturate_release_setup got no aligned edge, required one within 100 cycles");
    end
    step(15, 40);

    // reset mid-release with a key held through deassertion
    step(1, 24);
    step(15, 10);
    assert_rst();
    button = 5'd4;
    release_rst(4, 3);
    step(4, 20);

    // randomised key traffic
    repeat (40) begin
      b = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 31));
      step(b, int'($urandom_range(1, 24)));
    end
    step(15, 40);

    @(posedge clk); #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
